// File: rtl/butterfly_driver.sv
// butterfly_driver: runs one butterfly job through the control unit's toggle protocol and returns the captured LED results
module butterfly_driver #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       job_valid,
  output logic       job_ready,
  input  logic [2:0] job_tw,
  input  logic [7:0] job_reb,
  input  logic [7:0] job_rea,
  output logic       control,
  output logic [7:0] sswitch,
  input  logic [7:0] led_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_rey,
  output logic [7:0] res_imy,
  output logic [7:0] res_rez,
  output logic [7:0] res_imz
);
  typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;
  state_t state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] tw_q, tw_d;
  logic [7:0] reb_q, reb_d, rea_q, rea_d;
  logic [7:0] rey_q, rey_d, imy_q, imy_d, rez_q, rez_d, imz_q, imz_d;
  logic [7:0] sswitch_q, sswitch_d;
  logic control_q, control_d, job_ready_q, job_ready_d, res_valid_q, res_valid_d;
  logic accept, last, cap, run;
  always_comb begin
    accept = (state_q == IDLE) && job_valid && job_ready_q;
    last = cnt_q == 8'(HOLD - 1);
    state_d = state_q;
    phase_d = phase_q;
    cnt_d = cnt_q;
    tw_d = tw_q;
    reb_d = reb_q;
    rea_d = rea_q;
    if (accept) begin
      state_d = RUN;
      phase_d = 4'd0;
      cnt_d = 8'd0;
      tw_d = job_tw;
      reb_d = job_reb;
      rea_d = job_rea;
    end else if (state_q == RUN) begin
      cnt_d = last ? 8'd0 : cnt_q + 8'd1;
      phase_d = last ? phase_q + 4'd1 : phase_q;
      if (last && phase_q == 4'd9) state_d = RESULT;
    end else if (state_q == RESULT && res_ready) begin
      state_d = IDLE;
    end
    cap = (state_q == RUN) && last;
    rey_d = (cap && phase_q == 4'd5) ? led_out : rey_q;
    imy_d = (cap && phase_q == 4'd6) ? led_out : imy_q;
    rez_d = (cap && phase_q == 4'd7) ? led_out : rez_q;
    imz_d = (cap && phase_q == 4'd8) ? led_out : imz_q;
    // outputs are computed from next-state so the registered levels line up with the phase they belong to
    run = state_d == RUN;
    control_d = !run || phase_d[0];
    sswitch_d = !run ? 8'd0 :
                (phase_d == 4'd1 || phase_d == 4'd2) ? {5'b0, tw_d} :
                (phase_d == 4'd3 || phase_d == 4'd4) ? reb_d :
                (phase_d == 4'd5 || phase_d == 4'd6) ? rea_d : 8'd0;
    // one settling cycle in IDLE after a result before offering ready again
    job_ready_d = (state_d == IDLE) && (state_q == IDLE);
    res_valid_d = state_d == RESULT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 4'd0;
      cnt_q <= 8'd0;
      tw_q <= 3'd0;
      reb_q <= 8'd0;
      rea_q <= 8'd0;
      rey_q <= 8'd0;
      imy_q <= 8'd0;
      rez_q <= 8'd0;
      imz_q <= 8'd0;
      control_q <= 1'b1;
      sswitch_q <= 8'd0;
      job_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      tw_q <= tw_d;
      reb_q <= reb_d;
      rea_q <= rea_d;
      rey_q <= rey_d;
      imy_q <= imy_d;
      rez_q <= rez_d;
      imz_q <= imz_d;
      control_q <= control_d;
      sswitch_q <= sswitch_d;
      job_ready_q <= job_ready_d;
      res_valid_q <= res_valid_d;
    end
  end
  assign job_ready = job_ready_q;
  assign control = control_q;
  assign sswitch = sswitch_q;
  assign res_valid = res_valid_q;
  assign res_rey = rey_q;
  assign res_imy = imy_q;
  assign res_rez = rez_q;
  assign res_imz = imz_q;
endmodule

// File: tb/tb_butterfly_driver.sv
// tb_butterfly_driver: directed checks of the butterfly job sequencer with a scripted LED stub
module tb_butterfly_driver;
  localparam int HOLD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic job_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [2:0] job_tw = 3'd0;
  logic [7:0] job_reb = 8'd0, job_rea = 8'd0, led_out = 8'd0;
  logic job_ready, control, res_valid;
  logic [7:0] sswitch, res_rey, res_imy, res_rez, res_imz;
  int n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0, first_acc = 0;
  butterfly_driver #(.HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_tw(job_tw), .job_reb(job_reb), .job_rea(job_rea),
    .control(control), .sswitch(sswitch), .led_out(led_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_rey(res_rey), .res_imy(res_imy), .res_rez(res_rez), .res_imz(res_imz)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // leds packs the values shown during p5..p8 as {rey, imy, rez, imz}; abort_k >= 0 resets mid-run
  task automatic run_job(input logic [2:0] tw, input logic [7:0] reb, input logic [7:0] rea,
                         input logic [31:0] leds, input int abort_k);
    int w, p, c;
    logic [7:0] exp_sw, lv;
    w = 0;
    job_tw = tw;
    job_reb = reb;
    job_rea = rea;
    job_valid = 1'b1;
    while (!job_ready && w < 100) begin
      tick;
      w++;
    end
    chk("job_ready_wait", {31'd0, job_ready}, 32'd1);
    acc_cyc = cyc;
    tick;
    job_valid = 1'b0;
    job_tw = ~tw;
    job_reb = ~reb;
    job_rea = ~rea;
    for (int k = 0; k < 10 * HOLD; k++) begin
      p = k / HOLD;
      c = k % HOLD;
      if (k == abort_k) begin
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_control", {31'd0, control}, 32'd1);
        chk("abort_sswitch", {24'd0, sswitch}, 32'd0);
        chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
        chk("abort_job_ready", {31'd0, job_ready}, 32'd0);
        return;
      end
      exp_sw = (p == 1 || p == 2) ? {5'b0, tw} : (p == 3 || p == 4) ? reb :
               (p == 5 || p == 6) ? rea : 8'h00;
      lv = (p == 5) ? leds[31:24] : (p == 6) ? leds[23:16] : (p == 7) ? leds[15:8] :
           (p == 8) ? leds[7:0] : 8'h00;
      led_out = (c == HOLD - 1) ? lv : ~lv;
      chk("control", {31'd0, control}, 32'(p % 2));
      chk("sswitch", {24'd0, sswitch}, {24'd0, exp_sw});
      chk("res_valid_early", {31'd0, res_valid}, 32'd0);
      chk("job_ready_run", {31'd0, job_ready}, 32'd0);
      tick;
    end
    chk("latency", 32'(cyc - acc_cyc), 32'(10 * HOLD + 1));
    chk("res_valid", {31'd0, res_valid}, 32'd1);
    chk("res_control", {31'd0, control}, 32'd1);
    chk("res_sswitch", {24'd0, sswitch}, 32'd0);
    chk("res_rey", {24'd0, res_rey}, {24'd0, leds[31:24]});
    chk("res_imy", {24'd0, res_imy}, {24'd0, leds[23:16]});
    chk("res_rez", {24'd0, res_rez}, {24'd0, leds[15:8]});
    chk("res_imz", {24'd0, res_imz}, {24'd0, leds[7:0]});
  endtask
  initial begin
    rst = 1'b1;
    tick;
    tick;
    chk("rst_control", {31'd0, control}, 32'd1);
    chk("rst_sswitch", {24'd0, sswitch}, 32'd0);
    chk("rst_job_ready", {31'd0, job_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_fields", {res_rey, res_imy, res_rez, res_imz}, 32'd0);
    rst = 1'b0;
    tick;
    chk("idle_job_ready", {31'd0, job_ready}, 32'd1);
    chk("idle_control", {31'd0, control}, 32'd1);
    // basic job with the consumer always ready
    res_ready = 1'b1;
    run_job(3'd3, 8'h40, 8'h10, 32'h11223344, -1);
    tick;
    chk("pulse_res_valid", {31'd0, res_valid}, 32'd0);
    chk("post_job_ready0", {31'd0, job_ready}, 32'd0);
    tick;
    chk("post_job_ready1", {31'd0, job_ready}, 32'd1);
    // result held under backpressure, new job offers ignored
    res_ready = 1'b0;
    run_job(3'd5, 8'hA5, 8'h3C, 32'hDEADBEEF, -1);
    job_valid = 1'b1;
    job_tw = 3'd7;
    job_reb = 8'h99;
    job_rea = 8'h66;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_fields", {res_rey, res_imy, res_rez, res_imz}, 32'hDEADBEEF);
      chk("hold_job_ready", {31'd0, job_ready}, 32'd0);
      chk("hold_control", {31'd0, control}, 32'd1);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    tick;
    chk("release_res_valid", {31'd0, res_valid}, 32'd0);
    tick;
    chk("release_job_ready", {31'd0, job_ready}, 32'd1);
    // reset during p4 cycle 2, then a clean job
    run_job(3'd2, 8'h81, 8'h7E, 32'h55555555, 4 * HOLD + 2);
    run_job(3'd6, 8'h01, 8'hFE, 32'h01020304, -1);
    // back-to-back jobs at the minimum interval
    run_job(3'd1, 8'h12, 8'h34, 32'hA1B2C3D4, -1);
    first_acc = acc_cyc;
    run_job(3'd4, 8'hF0, 8'h0F, 32'h5A6B7C8D, -1);
    chk("b2b_interval", 32'(acc_cyc - first_acc), 32'(10 * HOLD + 3));
    tick;
    chk("final_res_valid", {31'd0, res_valid}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
